// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE result bits per iteration.
module muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               accept;
  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Accumulator is {partial product, remaining multiplier bits}; low B bits are consumed per step.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0]   m);
    logic [WIDTH+B-1:0] part;
    logic [WIDTH+B-1:0] sum;
    part = '0;
    for (int i = 0; i < B; i++) begin
      if (x[i]) part = part + ({{B{1'b0}}, m} << i);
    end
    sum = {{B{1'b0}}, x[2*WIDTH-1:WIDTH]} + part;
    return {sum, x[WIDTH-1:B]};
  endfunction

  // Accumulator is {remainder, dividend/quotient}; quotient bits shift in from the right.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0]   d);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   diff;
    r = x[2*WIDTH-1:WIDTH];
    q = x[WIDTH-1:0];
    for (int i = 0; i < B; i++) begin
      ext  = {r, q[WIDTH-1]};
      q    = {q[WIDTH-2:0], 1'b0};
      diff = ext - {1'b0, d};
      if (!diff[WIDTH]) begin
        r    = diff[WIDTH-1:0];
        q[0] = 1'b1;
      end else begin
        r = ext[WIDTH-1:0];
      end
    end
    return {r, q};
  endfunction

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && start && !flush;
  assign sgn_a  = !op[0] && src_a[WIDTH-1];
  assign sgn_b  = !op[0] && src_b[WIDTH-1];
  assign a_mag  = sgn_a ? -src_a : src_a;
  assign b_mag  = sgn_b ? -src_b : src_b;

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (dbz_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  // Control and architectural HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            state <= S_CALC;
            count <= CNT_W'(ITER - 1);
          end
        end
        S_CALC: begin
          if (flush)              state <= S_IDLE;
          else if (count == '0)   state <= S_FIX;
          else                    count <= count - CNT_W'(1);
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= dbz_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q      <= op;
      neg_res_q <= sgn_a ^ sgn_b;
      neg_rem_q <= sgn_a;
      dbz_q     <= op[1] && (src_b == '0);
      a_raw_q   <= src_a;
      opnd_q    <= op[1] ? b_mag : a_mag;
      acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
    end else if (state == S_CALC) begin
      acc_q <= op_q[1] ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one 1-bit/cycle and one 4-bit/cycle instance share stimulus.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;

  logic        busy1, done1, dbz1;
  logic [31:0] hi1, lo1;
  logic        busy4, done4, dbz4;
  logic [31:0] hi4, lo4;

  int vectors = 0;
  int errors  = 0;

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy1), .done(done1), .div_by_zero(dbz1), .hi(hi1), .lo(lo1)
  );

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input bit sel4, output int cnt, output bit seen);
    cnt  = 0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (sel4 ? done4 : done1) seen = 1;
      else begin
        if (sel4 ? busy4 : busy1) cnt++;
        tick();
      end
    end
  endtask

  task automatic run_op(input bit sel4, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cnt, output bit seen);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    wait_done(sel4, cnt, seen);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || dbz1 !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy/done/dbz=%b%b%b expected 000", busy1, done1, dbz1);
    end
    vectors++;
    if (hi1 !== 32'h0 || lo1 !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi1, lo1);
    end
    vectors++;
    if (busy4 !== 1'b0 || hi4 !== 32'h0 || lo4 !== 32'h0) begin
      errors++; $display("FAIL reset_b4: busy=%b hi=%h lo=%h expected 0/0/0", busy4, hi4, lo4);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int cnt; bit seen;
    run_op(0, 2'b00, 32'hFFFFFFFD, 32'h00000005, cnt, seen);
    vectors++;
    if (!seen || cnt != 33) begin
      errors++; $display("FAIL mult_latency: done=%0d busy_cycles=%0d expected 1/33", seen, cnt);
    end
    vectors++;
    if (hi1 !== 32'hFFFFFFFF || lo1 !== 32'hFFFFFFF1 || dbz1 !== 1'b0) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h dbz=%b expected FFFFFFFF/FFFFFFF1/0", hi1, lo1, dbz1);
    end
    tick();
    vectors++;
    if (done1 !== 1'b0 || hi1 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL done_pulse: done=%b hi=%h expected 0/FFFFFFFF", done1, hi1);
    end
  endtask

  task automatic test_multu_div;
    int cnt; bit seen;
    run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt, seen);
    vectors++;
    if (!seen || hi1 !== 32'hFFFFFFFE || lo1 !== 32'h00000001) begin
      errors++; $display("FAIL multu: done=%0d hi=%h lo=%h expected 1/FFFFFFFE/00000001", seen, hi1, lo1);
    end
    run_op(0, 2'b10, 32'hFFFFFFF9, 32'h00000002, cnt, seen);
    vectors++;
    if (!seen || cnt != 33 || lo1 !== 32'hFFFFFFFD || hi1 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_neg: done=%0d cyc=%0d lo=%h hi=%h expected 1/33/FFFFFFFD/FFFFFFFF", seen, cnt, lo1, hi1);
    end
    run_op(0, 2'b10, 32'h00000007, 32'hFFFFFFFE, cnt, seen);
    vectors++;
    if (!seen || lo1 !== 32'hFFFFFFFD || hi1 !== 32'h00000001) begin
      errors++; $display("FAIL div_negdivisor: lo=%h hi=%h expected FFFFFFFD/00000001", lo1, hi1);
    end
  endtask

  task automatic test_div_zero;
    int cnt; bit seen;
    run_op(0, 2'b11, 32'h00000007, 32'h00000000, cnt, seen);
    vectors++;
    if (!seen || cnt != 33 || dbz1 !== 1'b1 || hi1 !== 32'h00000007 || lo1 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL divu_zero: cyc=%0d dbz=%b hi=%h lo=%h expected 33/1/00000007/FFFFFFFF", cnt, dbz1, hi1, lo1);
    end
    run_op(0, 2'b10, 32'hFFFFFFF9, 32'h00000000, cnt, seen);
    vectors++;
    if (!seen || dbz1 !== 1'b1 || hi1 !== 32'hFFFFFFF9 || lo1 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_zero_signed: dbz=%b hi=%h lo=%h expected 1/FFFFFFF9/FFFFFFFF", dbz1, hi1, lo1);
    end
    run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, cnt, seen);
    vectors++;
    if (!seen || lo1 !== 32'h80000000 || hi1 !== 32'h00000000 || dbz1 !== 1'b0) begin
      errors++; $display("FAIL div_overflow: lo=%h hi=%h dbz=%b expected 80000000/00000000/0", lo1, hi1, dbz1);
    end
  endtask

  task automatic test_mthi;
    int cnt; bit seen;
    hi_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0;
    vectors++;
    if (hi1 !== 32'h12345678) begin
      errors++; $display("FAIL mthi_idle: hi=%h expected 12345678", hi1);
    end
    lo_we = 1'b1; wdata = 32'hCAFEBABE;
    tick();
    lo_we = 1'b0;
    vectors++;
    if (lo1 !== 32'hCAFEBABE || hi1 !== 32'h12345678) begin
      errors++; $display("FAIL mtlo_idle: lo=%h hi=%h expected CAFEBABE/12345678", lo1, hi1);
    end
    start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    hi_we = 1'b0;
    vectors++;
    if (hi1 !== 32'h12345678) begin
      errors++; $display("FAIL mthi_busy: hi=%h expected 12345678", hi1);
    end
    start = 1'b1; op = 2'b01; src_a = 32'd100; src_b = 32'd100;
    tick();
    start = 1'b0;
    wait_done(0, cnt, seen);
    vectors++;
    if (!seen || hi1 !== 32'h00000000 || lo1 !== 32'h0000000C) begin
      errors++; $display("FAIL start_busy: done=%0d hi=%h lo=%h expected 1/00000000/0000000C", seen, hi1, lo1);
    end
    tick();
    vectors++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL not_queued: busy=%b expected 0", busy1);
    end
  endtask

  task automatic test_flush;
    bit saw_done;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11111111;
    tick();
    lo_we = 1'b1; hi_we = 1'b0; wdata = 32'h22222222;
    tick();
    lo_we = 1'b0;
    start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL flush_calc: busy=%b done=%b expected 0/0", busy1, done1);
    end
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done1) saw_done = 1;
      tick();
    end
    vectors++;
    if (saw_done || hi1 !== 32'h11111111 || lo1 !== 32'h22222222) begin
      errors++; $display("FAIL flush_hilo: done_seen=%0d hi=%h lo=%h expected 0/11111111/22222222", saw_done, hi1, lo1);
    end
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy=%b expected 0", busy1);
    end
    start = 1'b1; op = 2'b01; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy1 !== 1'b0 || hi1 !== 32'h0 || lo1 !== 32'h0 || done1 !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy1, done1, hi1, lo1);
    end
  endtask

  task automatic test_back_to_back;
    int cnt; bit seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_op(1, 2'b01, 32'h0000FFFF, 32'h00010001, cnt, seen);
    vectors++;
    if (!seen || cnt != 9 || hi4 !== 32'h00000000 || lo4 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL b4_multu: done=%0d cyc=%0d hi=%h lo=%h expected 1/9/00000000/FFFFFFFF", seen, cnt, hi4, lo4);
    end
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    vectors++;
    if (busy4 !== 1'b1) begin
      errors++; $display("FAIL b4_b2b_accept: busy=%b expected 1", busy4);
    end
    wait_done(1, cnt, seen);
    vectors++;
    if (!seen || cnt != 9 || lo4 !== 32'h0000000E || hi4 !== 32'h00000002) begin
      errors++; $display("FAIL b4_divu: cyc=%0d lo=%h hi=%h expected 9/0000000E/00000002", cnt, lo4, hi4);
    end
    run_op(1, 2'b10, 32'hFFFFFF9C, 32'd7, cnt, seen);
    vectors++;
    if (!seen || lo4 !== 32'hFFFFFFF2 || hi4 !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL b4_div: lo=%h hi=%h expected FFFFFFF2/FFFFFFFE", lo4, hi4);
    end
    run_op(1, 2'b00, 32'h00000007, 32'hFFFFFFFE, cnt, seen);
    vectors++;
    if (!seen || hi4 !== 32'hFFFFFFFF || lo4 !== 32'hFFFFFFF2) begin
      errors++; $display("FAIL b4_mult: hi=%h lo=%h expected FFFFFFFF/FFFFFFF2", hi4, lo4);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_mult();
    test_multu_div();
    test_div_zero();
    test_mthi();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO registers.
- Replaces the single-cycle in-pipeline divide path. The execute stage issues operations to it; the hazard unit stalls on `busy` whenever an MFHI, MFLO, MTHI, MTLO, MULT or DIV depends on it.
- Supports signed and unsigned multiply and divide, direct HI/LO writes, cancellation on flush, and a configurable number of result bits per cycle.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1: result bits resolved per iteration. Legal values are 1, 2 and 4, and must divide WIDTH.
- ITER, derived, WIDTH/BITS_PER_CYCLE: number of iteration cycles.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request an operation; sampled only while idle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  multiplicand or dividend
- src_b  in  WIDTH  multiplier or divisor
- flush  in  1  abort any operation in progress
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  data for MTHI/MTLO
- busy  out  1  operation in progress (combinational from state)
- done  out  1  one-cycle pulse; hi/lo hold the new result
- div_by_zero  out  1  valid while done=1 for a DIV or DIVU with src_b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, hi=0, lo=0, done=0, div_by_zero=0, iteration counter=0. Reset overrides every other input.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, lasts ITER cycles.
  - FIX: busy=1, lasts 1 cycle.
- IDLE→CALC: on an edge with start=1 and flush=0.
  - Latch op and sign flags.
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Counter loads ITER-1.
- CALC, multiply: shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 2*WIDTH accumulator.
- CALC, divide: restoring division producing BITS_PER_CYCLE quotient bits per cycle.
- CALC→FIX: at the edge where counter=0. Otherwise the counter decrements.
- FIX→IDLE, at that edge:
  - Apply sign correction.
  - Write hi/lo.
  - Set done=1 for exactly one cycle.
  - Set div_by_zero per result.
- Latency: start sampled at edge 0 → busy high for ITER+1 cycles → done=1 with new hi/lo in the cycle after edge ITER+1. For WIDTH=32, BITS_PER_CYCLE=1 that is 33 cycles.
- A new start is accepted in the cycle where done=1.
- Multiply result: hi = upper WIDTH bits and lo = lower WIDTH bits of the 2*WIDTH product. Signed when op=00.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: full latency. hi=src_a as latched, lo=all ones, div_by_zero=1. Identical for DIV and DIVU.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, no flag.
- start while busy: ignored, not queued.
- flush:
  - In CALC or FIX: the state returns to IDLE at the edge, hi/lo are unchanged and done stays 0.
  - In IDLE: it suppresses a simultaneous start.
- hi_we/lo_we:
  - Take effect at the edge only when busy=0. Ignored while busy.
  - If asserted with an accepted start, the write lands now and the operation result overwrites it later.
- Operands are latched at start; src_a and src_b may change during CALC.
- Outputs hi, lo, done and div_by_zero are registered.

Test Plan:
- MULT, src_a=FFFFFFFD (-3), src_b=00000005 → done after 33 cycles; hi=FFFFFFFF, lo=FFFFFFF1; busy high for exactly 33 cycles.
- MULTU, FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001. Then DIV FFFFFFF9 (-7)/00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 00000007/00000000 → div_by_zero=1, hi=00000007, lo=FFFFFFFF. Then DIV 80000000/FFFFFFFF → lo=80000000, hi=00000000, div_by_zero=0.
- MTHI wdata=12345678 while idle → hi=12345678 next cycle. Repeat while busy → ignored. start during CALC → ignored, and the original result is unaffected.
- flush at cycle 10 of a DIV → busy drops next cycle, no done, hi/lo keep their prior values. reset mid-CALC → hi=lo=0, idle.
- BITS_PER_CYCLE=4 build: MULTU 0000FFFF×00010001 → done after 9 cycles with hi=00000000, lo=FFFFFFFF. Back-to-back start in the done cycle is accepted.
